// File: rtl/codec_tx.sv
// I2S transmitter for the equalizer output: derives MCLK/SCLK/LRclk from a free-running
// counter and serialises the held left/right samples MSB-first with the one-bit I2S delay.
module codec_tx (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] lft_smpl,
    input  logic [15:0] rht_smpl,
    input  logic        wrt_smpl,
    input  logic        clr_undr,
    output logic        MCLK,
    output logic        SCLK,
    output logic        LRclk,
    output logic        SDout,
    output logic        frm_strt,
    output logic        underrun,
    output logic        running
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_reg, state_next;
    logic [9:0]  cnt_reg, cnt_next;
    logic [31:0] shft_reg, shft_next;
    logic [15:0] lft_hold_reg, lft_hold_next;
    logic [15:0] rht_hold_reg, rht_hold_next;
    logic        fresh_reg, fresh_next;
    logic        underrun_reg, underrun_next;
    logic        sdout_reg, sdout_next;

    logic        shift_ev;
    logic        load_ev;
    logic        do_load;

    assign shift_ev = (cnt_reg[4:0] == 5'h1F);
    assign load_ev  = (cnt_reg == 10'h01F);
    // In IDLE a load only happens once a sample is waiting; in RUN every frame reloads.
    assign do_load  = load_ev && ((state_reg == RUN) || fresh_reg);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= 10'd0;
            shft_reg     <= 32'd0;
            lft_hold_reg <= 16'd0;
            rht_hold_reg <= 16'd0;
            fresh_reg    <= 1'b0;
            underrun_reg <= 1'b0;
            sdout_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            shft_reg     <= shft_next;
            lft_hold_reg <= lft_hold_next;
            rht_hold_reg <= rht_hold_next;
            fresh_reg    <= fresh_next;
            underrun_reg <= underrun_next;
            sdout_reg    <= sdout_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg + 10'd1;
        shft_next     = shft_reg;
        lft_hold_next = lft_hold_reg;
        rht_hold_next = rht_hold_reg;
        fresh_next    = fresh_reg;
        underrun_next = underrun_reg;
        sdout_next    = sdout_reg;

        if (clr_undr) begin
            underrun_next = 1'b0;
        end

        if (do_load) begin
            sdout_next = lft_hold_reg[15];
            shft_next  = {lft_hold_reg[14:0], rht_hold_reg, 1'b0};
            fresh_next = 1'b0;
            state_next = RUN;
            if ((state_reg == RUN) && !fresh_reg) begin
                underrun_next = 1'b1;
            end
        end else if (shift_ev && (state_reg == RUN)) begin
            sdout_next = shft_reg[31];
            shft_next  = {shft_reg[30:0], 1'b0};
        end

        // Capture comes last so a coincident load sends the old pair and the new one stays fresh.
        if (wrt_smpl) begin
            lft_hold_next = lft_smpl;
            rht_hold_next = rht_smpl;
            fresh_next    = 1'b1;
        end
    end

    assign MCLK     = cnt_reg[1];
    assign SCLK     = cnt_reg[4];
    assign LRclk    = cnt_reg[9];
    assign frm_strt = (cnt_reg == 10'h3FF);
    assign SDout    = sdout_reg;
    assign underrun = underrun_reg;
    assign running  = (state_reg == RUN);

endmodule
